// File: rtl/parity_checker_core.sv
// parity_checker_core: even/odd parity check with a registered per-word result and link statistics.
// Defining PARITY_CHECKER_ERR_CNT_EN adds the err_cnt port and its saturating error counter.
module parity_checker_core #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              parity_bit,
    input  logic              parity_type,
    input  logic              in_valid,
    input  logic              clr,
    output logic              error,
    output logic              chk_valid,
    output logic              err_q,
    output logic              sticky_err,
    output logic [CNT_W-1:0]  word_cnt
`ifdef PARITY_CHECKER_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    logic             err_p0;
    logic             vld_p1;
    logic             err_p1;
    logic             sticky_p1;
    logic [CNT_W-1:0] word_cnt_p1;
`ifdef PARITY_CHECKER_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_p1;
`endif

    // Counters stick at all-ones so a long-running link never reports a wrapped small value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Stage p0: combinational check, deliberately independent of in_valid and reset.
    assign err_p0 = (^data_in) ^ parity_bit ^ parity_type;
    assign error  = err_p0;

    // Stage p0 -> p1: per-word result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                err_p1 <= err_p0;
            end
        end
    end

    // Stage p0 -> p1: statistics; clr wins over a word arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_p1   <= 1'b0;
            word_cnt_p1 <= '0;
`ifdef PARITY_CHECKER_ERR_CNT_EN
            err_cnt_p1  <= '0;
`endif
        end else if (clr) begin
            sticky_p1   <= 1'b0;
            word_cnt_p1 <= '0;
`ifdef PARITY_CHECKER_ERR_CNT_EN
            err_cnt_p1  <= '0;
`endif
        end else if (in_valid) begin
            word_cnt_p1 <= sat_inc(word_cnt_p1);
            if (err_p0) begin
                sticky_p1  <= 1'b1;
`ifdef PARITY_CHECKER_ERR_CNT_EN
                err_cnt_p1 <= sat_inc(err_cnt_p1);
`endif
            end
        end
    end

    assign chk_valid  = vld_p1;
    assign err_q      = err_p1;
    assign sticky_err = sticky_p1;
    assign word_cnt   = word_cnt_p1;
`ifdef PARITY_CHECKER_ERR_CNT_EN
    assign err_cnt    = err_cnt_p1;
`endif

endmodule

// File: tb/tb_parity_checker_core.sv
// Testbench for parity_checker_core: directed scenarios plus randomized words against a parity reference model.
// A second instance with CNT_W=2 exercises counter saturation alongside the default-width instance.
module tb_parity_checker_core;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          parity_bit = 1'b0;
    logic          parity_type = 1'b0;
    logic          in_valid = 1'b0;
    logic          clr = 1'b0;

    logic          error, chk_valid, err_q, sticky_err;
    logic [15:0]   word_cnt;
    logic          error2, chk_valid2, err_q2, sticky_err2;
    logic [1:0]    word_cnt2;
`ifdef PARITY_CHECKER_ERR_CNT_EN
    logic [15:0]   err_cnt;
    logic [1:0]    err_cnt2;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state (counts kept unsaturated; saturation applied when comparing)
    bit m_chk, m_errq, m_sticky;
    int m_words, m_errs;

    parity_checker_core #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_bit(parity_bit),
        .parity_type(parity_type), .in_valid(in_valid), .clr(clr),
        .error(error), .chk_valid(chk_valid), .err_q(err_q), .sticky_err(sticky_err),
        .word_cnt(word_cnt)
`ifdef PARITY_CHECKER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    parity_checker_core #(.DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .parity_bit(parity_bit),
        .parity_type(parity_type), .in_valid(in_valid), .clr(clr),
        .error(error2), .chk_valid(chk_valid2), .err_q(err_q2), .sticky_err(sticky_err2),
        .word_cnt(word_cnt2)
`ifdef PARITY_CHECKER_ERR_CNT_EN
        , .err_cnt(err_cnt2)
`endif
    );

    always #5 clk = ~clk;

    // Error when the total number of ones (data plus parity bit) has the wrong evenness for the mode.
    function automatic bit ref_err(input logic [DW-1:0] d, input logic pb, input logic pt);
        int ones;
        ones = $countones(d) + int'(pb);
        return pt ? (ones % 2 == 0) : (ones % 2 == 1);
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_chk = 0; m_errq = 0; m_sticky = 0; m_words = 0; m_errs = 0;
    endtask

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit e;
        e = ref_err(data_in, parity_bit, parity_type);
        m_chk = in_valid;
        if (in_valid) m_errq = e;
        if (clr) begin
            m_sticky = 0; m_words = 0; m_errs = 0;
        end else if (in_valid) begin
            m_words++;
            if (e) begin
                m_errs++;
                m_sticky = 1;
            end
        end
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic pb, input logic pt,
                         input logic v, input logic c);
        data_in = d; parity_bit = pb; parity_type = pt; in_valid = v; clr = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++;
        if ({chk_valid, err_q, sticky_err} !== 3'b000 || word_cnt !== 16'd0) begin
            n_miss++;
            $display("FAIL reset_state: got chk=%b errq=%b sticky=%b cnt=%0d, want all 0",
                     chk_valid, err_q, sticky_err, word_cnt);
        end
        data_in = 4'b1011; parity_bit = 1'b0; parity_type = 1'b0;
        #1;
        n_vec++;
        if (error !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_error_tracks: got %b want 1", error);
        end
        model_reset();
        #7 rst_n = 1'b1;
        drive(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if ({chk_valid, err_q, sticky_err} !== 3'b111 || word_cnt !== 16'd1) begin
            n_miss++;
            $display("FAIL first_edge_after_reset: got chk=%b errq=%b sticky=%b cnt=%0d, want 1 1 1 1",
                     chk_valid, err_q, sticky_err, word_cnt);
        end
    endtask

    task automatic test_comb();
        logic [4:0] cases [4];
        logic       want  [4];
        cases[0] = {4'b1011, 1'b1}; want[0] = 1'b0;
        cases[1] = {4'b1011, 1'b0}; want[1] = 1'b1;
        cases[2] = {4'b1011, 1'b0}; want[2] = 1'b0;
        cases[3] = {4'b1011, 1'b1}; want[3] = 1'b1;
        in_valid = 1'b0; clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = cases[i][4:1]; parity_bit = cases[i][0]; parity_type = (i >= 2);
            #1;
            n_vec++;
            if (error !== want[i]) begin
                n_miss++;
                $display("FAIL comb_case%0d: got error=%b want %b", i, error, want[i]);
            end
        end
    endtask

    task automatic test_sequence();
        logic       pbs [3];
        logic       pts [3];
        logic       eq  [3];
        logic       st  [3];
        pbs[0] = 1; pts[0] = 0; eq[0] = 0; st[0] = 0;
        pbs[1] = 0; pts[1] = 0; eq[1] = 1; st[1] = 1;
        pbs[2] = 0; pts[2] = 1; eq[2] = 0; st[2] = 1;
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b1011, pbs[i], pts[i], 1'b1, 1'b0);
            n_vec++;
            if ({chk_valid, err_q, sticky_err} !== {1'b1, eq[i], st[i]}) begin
                n_miss++;
                $display("FAIL seq_word%0d: got chk=%b errq=%b sticky=%b want 1 %b %b",
                         i, chk_valid, err_q, sticky_err, eq[i], st[i]);
            end
        end
        n_vec++;
        if (word_cnt !== 16'd3) begin
            n_miss++;
            $display("FAIL seq_word_cnt: got %0d want 3", word_cnt);
        end
`ifdef PARITY_CHECKER_ERR_CNT_EN
        n_vec++;
        if (err_cnt !== 16'd1) begin
            n_miss++;
            $display("FAIL seq_err_cnt: got %0d want 1", err_cnt);
        end
`endif
        drive(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (chk_valid !== 1'b0 || err_q !== 1'b0 || word_cnt !== 16'd3) begin
            n_miss++;
            $display("FAIL idle_hold: got chk=%b errq=%b cnt=%0d want 0 0 3", chk_valid, err_q, word_cnt);
        end
    endtask

    task automatic test_clr_priority();
        drive(4'b1011, 1'b0, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if ({chk_valid, err_q, sticky_err} !== 3'b110 || word_cnt !== 16'd0) begin
            n_miss++;
            $display("FAIL clr_priority: got chk=%b errq=%b sticky=%b cnt=%0d want 1 1 0 0",
                     chk_valid, err_q, sticky_err, word_cnt);
        end
`ifdef PARITY_CHECKER_ERR_CNT_EN
        n_vec++;
        if (err_cnt !== 16'd0) begin
            n_miss++;
            $display("FAIL clr_err_cnt: got %0d want 0", err_cnt);
        end
`endif
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if (word_cnt2 !== 2'(sat(i + 1, 2))) begin
                n_miss++;
                $display("FAIL sat_word_cnt2_step%0d: got %0d want %0d", i, word_cnt2, sat(i + 1, 2));
            end
        end
        n_vec++;
        if (word_cnt !== 16'd5) begin
            n_miss++;
            $display("FAIL sat_wide_cnt: got %0d want 5", word_cnt);
        end
`ifdef PARITY_CHECKER_ERR_CNT_EN
        n_vec++;
        if (err_cnt2 !== 2'd3) begin
            n_miss++;
            $display("FAIL sat_err_cnt2: got %0d want 3", err_cnt2);
        end
`endif
    endtask

    task automatic test_random();
        logic [DW-1:0] d;
        logic          pb, pt, v, c;
        for (int i = 0; i < 300; i++) begin
            d  = DW'($urandom);
            pb = 1'($urandom);
            pt = 1'($urandom);
            v  = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 39) == 0);
            data_in = d; parity_bit = pb; parity_type = pt; in_valid = v; clr = c;
            #1;
            n_vec++;
            if (error !== ref_err(d, pb, pt)) begin
                n_miss++;
                $display("FAIL rand_error[%0d]: got %b want %b", i, error, ref_err(d, pb, pt));
            end
            @(posedge clk);
            model_edge();
            #1;
            n_vec++;
            if ({chk_valid, err_q, sticky_err} !== {m_chk, m_errq, m_sticky}) begin
                n_miss++;
                $display("FAIL rand_flags[%0d]: got %b%b%b want %b%b%b", i,
                         chk_valid, err_q, sticky_err, m_chk, m_errq, m_sticky);
            end
            n_vec++;
            if (word_cnt !== 16'(sat(m_words, 16)) || word_cnt2 !== 2'(sat(m_words, 2))) begin
                n_miss++;
                $display("FAIL rand_word_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                         word_cnt, word_cnt2, sat(m_words, 16), sat(m_words, 2));
            end
`ifdef PARITY_CHECKER_ERR_CNT_EN
            n_vec++;
            if (err_cnt !== 16'(sat(m_errs, 16)) || err_cnt2 !== 2'(sat(m_errs, 2))) begin
                n_miss++;
                $display("FAIL rand_err_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                         err_cnt, err_cnt2, sat(m_errs, 16), sat(m_errs, 2));
            end
`endif
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) drive(4'b0001, 1'b0, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({chk_valid, err_q, sticky_err} !== 3'b000 || word_cnt !== 16'd0 || word_cnt2 !== 2'd0) begin
            n_miss++;
            $display("FAIL mid_reset_clear: got chk=%b errq=%b sticky=%b cnt=%0d cnt2=%0d want all 0",
                     chk_valid, err_q, sticky_err, word_cnt, word_cnt2);
        end
`ifdef PARITY_CHECKER_ERR_CNT_EN
        n_vec++;
        if (err_cnt !== 16'd0) begin
            n_miss++;
            $display("FAIL mid_reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
        data_in = 4'b0011; parity_bit = 1'b0; parity_type = 1'b0;
        #1;
        n_vec++;
        if (error !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_reset_error_a: got %b want 0", error);
        end
        parity_bit = 1'b1;
        #1;
        n_vec++;
        if (error !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_reset_error_b: got %b want 1", error);
        end
        model_reset();
        #1 rst_n = 1'b1;
        drive(4'b0111, 1'b0, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if ({chk_valid, err_q, sticky_err} !== 3'b100 || word_cnt !== 16'd1) begin
            n_miss++;
            $display("FAIL after_mid_reset: got chk=%b errq=%b sticky=%b cnt=%0d want 1 0 0 1",
                     chk_valid, err_q, sticky_err, word_cnt);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_comb();
        test_sequence();
        test_clr_priority();
        test_saturation();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/parity_checker_core.md
# parity_checker_core

Even/odd parity checker for a parallel data word with an attached parity bit. It provides a combinational error flag for immediate use. It also registers per-word check results and keeps statistics: a sticky error flag, a checked-word count and an optional error count. It sits on the receive side of a link, after the data/parity capture register, and feeds link-health monitoring.

## Interface
Parameters:
- DATA_W, 4: data word width (≥1).
- CNT_W, 16: statistics counter width (≥2).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  received data word.
- parity_bit  in  1  received parity bit.
- parity_type  in  1  0 = even parity, 1 = odd parity.
- in_valid  in  1  data_in/parity_bit/parity_type qualify a word this cycle.
- clr  in  1  synchronous clear of sticky flag and counters.
- error  out  1  combinational parity error for current inputs, independent of in_valid.
- chk_valid  out  1  one-cycle pulse; err_q is valid.
- err_q  out  1  registered error of last valid word.
- sticky_err  out  1  set by any counted erroneous word; held until clr/reset.
- word_cnt  out  CNT_W  saturating count of checked words.
- err_cnt  out  CNT_W  saturating count of erroneous words (present only with macro, see Configuration).

## Operation
- error = XOR-reduce(data_in) ^ parity_bit ^ parity_type.
- Even mode: total count of ones in data_in plus parity_bit must be even. Odd mode: that total must be odd.
- error is purely combinational. It ignores clk, rst_n and in_valid.
- On a clock edge with in_valid=1: err_q <= error and chk_valid <= 1. Otherwise chk_valid <= 0 and err_q holds.
- Statistics, when in_valid=1 and clr=0:
  - word_cnt increments.
  - If error=1: sticky_err <= 1 and err_cnt increments.
- Counters saturate at 2^CNT_W−1 and never wrap.
- clr=1: sticky_err, word_cnt and err_cnt go to 0 on that edge.
- clr has priority over a simultaneous in_valid. That word still updates err_q/chk_valid but is not counted and does not set sticky_err.
- parity_type may change on any cycle. Each word is checked with the parity_type present in its own valid cycle.

## Timing
- error: zero-cycle combinational path.
- err_q/chk_valid: latency 1 cycle after the in_valid edge. Back-to-back words are accepted every cycle with no stalls.
- Statistics become visible 1 cycle after the qualifying edge.
- Reset (rst_n=0, asynchronous, at any time including mid-stream) forces chk_valid=0, err_q=0, sticky_err=0, word_cnt=0 and err_cnt=0 immediately. The first edge after deassertion processes inputs normally.
- Reset behaviour of error: follows inputs, is not reset.

## Configuration
- Macro PARITY_CHECKER_ERR_CNT_EN.
  - Defined: err_cnt port and counter are present, with the behaviour above.
  - Undefined: err_cnt port and its register are omitted entirely. All other behaviour is unchanged.

## Test plan
- Even, data_in=4'b1011, parity_bit=1 -> error=0. parity_bit=0 -> error=1.
- Odd, data_in=4'b1011, parity_bit=0 -> error=0. parity_bit=1 -> error=1.
- Sequence of in_valid words on consecutive edges:
  - Words: even 1011/1, then even 1011/0, then odd 1011/0.
  - Required: err_q sequence 0,1,0, each on the edge after its input.
  - Required: chk_valid high for 3 cycles; sticky_err=1 from the second result onward.
  - Required: word_cnt=3, err_cnt=1.
- clr asserted with an erroneous in_valid word -> err_q=1 and chk_valid=1, but sticky_err=0, word_cnt=0, err_cnt=0.
- CNT_W=2: apply 5 erroneous valid words -> word_cnt and err_cnt hold at 3 and do not wrap.
- rst_n pulsed low between clock edges after errors have accumulated -> all registered outputs return to 0 immediately without a clock edge. error still tracks the inputs.
